// File: rtl/datapath_unit.sv
// Execution datapath: 16-entry register file, 8-function ALU and a
// synchronous data memory, driven each cycle by the control unit's control word.

// Register file: two asynchronous read ports, one synchronous write port.
module dp_regfile #(
   parameter int DW    = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] rf [DEPTH];

   // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
   assign rdata_a = rf[raddr_a];
   assign rdata_b = rf[raddr_b];

   // Reset clears every entry and wins over a pending write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      end else if (we) begin
         rf[waddr] <= wdata;
      end
   end

endmodule

// ALU: unsigned, result truncated to DW bits, c is the 17th bit of the raw result.
module dp_alu #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [2:0]    sel,
   output logic [DW-1:0] y,
   output logic          c
);

   logic [DW:0] res;

   // Zero-extended operands make bit DW the carry for add/inc and the borrow for sub.
   always_comb begin
      res = '0;
      case (sel)
         3'b000: res = '0;
         3'b001: res = {1'b0, a} + {1'b0, b};
         3'b010: res = {1'b0, a} - {1'b0, b};
         3'b011: res = {1'b0, a};
         3'b100: res = {1'b0, a ^ b};
         3'b101: res = {1'b0, a | b};
         3'b110: res = {1'b0, a & b};
         3'b111: res = {1'b0, a} + {{DW{1'b0}}, 1'b1};
         default: res = '0;
      endcase
   end

   assign y = res[DW-1:0];
   assign c = res[DW];

endmodule

// Data memory: synchronous write, registered read with one cycle of latency.
module dp_dmem #(
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [DEPTH];

   // Array has no reset so it maps onto block RAM; writes are blocked during reset.
   always_ff @(posedge clk) begin
      if (we && !reset) mem[addr] <= wdata;
   end

   // Read register samples the old word on a same-address write; reset drops a pending load.
   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= mem[addr];
   end

endmodule

// Top: wires the three blocks together and keeps the ALU flags.
module datapath_unit #(
   parameter int DW       = 16,
   parameter int RF_DEPTH = 16,
   parameter int DM_DEPTH = 256,
   localparam int RA      = $clog2(RF_DEPTH),
   localparam int DA      = $clog2(DM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DA-1:0] D_addr,
   input  logic          D_wr,
   input  logic          RF_s,
   input  logic          RF_W_en,
   input  logic [RA-1:0] RF_W_addr,
   input  logic [RA-1:0] RF_Ra_addr,
   input  logic [RA-1:0] RF_Rb_addr,
   input  logic [2:0]    ALU_s0,
   output logic [DW-1:0] Ra_data,
   output logic [DW-1:0] Rb_data,
   output logic [DW-1:0] ALU_out,
   output logic [DW-1:0] W_data,
   output logic          zero_flag,
   output logic          carry_flag
);

   logic [DW-1:0] dm_q;
   logic          alu_c;

   dp_regfile #(.DW(DW), .DEPTH(RF_DEPTH)) u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (RF_W_en),
      .waddr   (RF_W_addr),
      .wdata   (W_data),
      .raddr_a (RF_Ra_addr),
      .raddr_b (RF_Rb_addr),
      .rdata_a (Ra_data),
      .rdata_b (Rb_data)
   );

   dp_alu #(.DW(DW)) u_alu (
      .a   (Ra_data),
      .b   (Rb_data),
      .sel (ALU_s0),
      .y   (ALU_out),
      .c   (alu_c)
   );

   // Stores always take their data from read port A.
   dp_dmem #(.DW(DW), .DEPTH(DM_DEPTH)) u_dm (
      .clk   (clk),
      .reset (reset),
      .we    (D_wr),
      .addr  (D_addr),
      .wdata (Ra_data),
      .q     (dm_q)
   );

   assign W_data = RF_s ? dm_q : ALU_out;

   // Flags track only ALU-sourced register writes; loads leave them untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
      end else if (RF_W_en && !RF_s) begin
         zero_flag  <= (ALU_out == '0);
         carry_flag <= alu_c;
      end
   end

endmodule

// File: tb/tb_datapath_unit.sv
// Directed-vector bench for datapath_unit with hand-computed expectations.
module tb_datapath_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  D_addr;
   logic        D_wr;
   logic        RF_s;
   logic        RF_W_en;
   logic [3:0]  RF_W_addr;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  ALU_s0;
   logic [15:0] Ra_data;
   logic [15:0] Rb_data;
   logic [15:0] ALU_out;
   logic [15:0] W_data;
   logic        zero_flag;
   logic        carry_flag;

   int n_vec = 0;
   int n_bad = 0;

   datapath_unit dut (
      .clk        (clk),
      .reset      (reset),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_en    (RF_W_en),
      .RF_W_addr  (RF_W_addr),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .Ra_data    (Ra_data),
      .Rb_data    (Rb_data),
      .ALU_out    (ALU_out),
      .W_data     (W_data),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      D_wr    = 1'b0;
      RF_s    = 1'b0;
      RF_W_en = 1'b0;
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] wa, input logic wen);
      ALU_s0     = op;
      RF_Ra_addr = ra;
      RF_Rb_addr = rb;
      RF_W_addr  = wa;
      RF_W_en    = wen;
      RF_s       = 1'b0;
      D_wr       = 1'b0;
      #1;
   endtask

   task automatic rd(input string tag, input logic [3:0] r, input logic [15:0] exp);
      RF_Ra_addr = r;
      #1;
      chk(tag, Ra_data, exp);
   endtask

   // Build a constant in register r: clear, then shift-and-increment MSB first.
   task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
      drive(3'b000, r, r, r, 1'b1);
      step();
      for (int i = 15; i >= 0; i--) begin
         drive(3'b001, r, r, r, 1'b1);
         step();
         if (v[i]) begin
            drive(3'b111, r, r, r, 1'b1);
            step();
         end
      end
      idle();
   endtask

   task automatic store(input logic [7:0] a, input logic [3:0] r);
      RF_W_en    = 1'b0;
      RF_s       = 1'b0;
      RF_Ra_addr = r;
      D_addr     = a;
      D_wr       = 1'b1;
      step();
      D_wr = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; D_addr = '0; D_wr = 1'b0; RF_s = 1'b0; RF_W_en = 1'b0;
      RF_W_addr = '0; RF_Ra_addr = '0; RF_Rb_addr = '0; ALU_s0 = '0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_ra", Ra_data, 16'h0000);
      chk("rst_zf", {15'd0, zero_flag}, 16'h0000);
      chk("rst_cf", {15'd0, carry_flag}, 16'h0000);

      // Reset: contents of RF cleared, data memory retained, D_wr/RF_W_en blocked
      set_reg(4'd14, 16'hBEEF);
      store(8'd5, 4'd14);
      set_reg(4'd3, 16'h1234);
      rd("pre_r3", 4'd3, 16'h1234);
      drive(3'b001, 4'd0, 4'd0, 4'd13, 1'b1);      // 0+0 -> zero_flag=1
      step();
      chk("pre_zf", {15'd0, zero_flag}, 16'h0001);
      reset = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd3; RF_s = 1'b1;
      D_wr = 1'b1; D_addr = 8'd5; RF_Ra_addr = 4'd3;
      step();
      reset = 1'b0; RF_W_en = 1'b0; D_wr = 1'b0;
      #1;
      chk("rst_dmq", W_data, 16'h0000);
      chk("rst_zf2", {15'd0, zero_flag}, 16'h0000);
      chk("rst_cf2", {15'd0, carry_flag}, 16'h0000);
      for (int r = 0; r < 16; r++) rd($sformatf("rst_r%0d", r), 4'(r), 16'h0000);
      step();
      chk("rst_mem5", W_data, 16'hBEEF);
      idle();

      // LOAD mem[11]=7 into r1, flags hold (zero=1, carry=0 set beforehand)
      set_reg(4'd14, 16'h0007);
      store(8'd11, 4'd14);
      drive(3'b001, 4'd0, 4'd0, 4'd13, 1'b1);
      step();
      idle();
      D_addr = 8'd11;
      step();
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd1;
      #1;
      chk("ld_wdata", W_data, 16'h0007);
      step();
      idle();
      rd("ld_r1", 4'd1, 16'h0007);
      chk("ld_zf", {15'd0, zero_flag}, 16'h0001);
      chk("ld_cf", {15'd0, carry_flag}, 16'h0000);

      // SUB with borrow: 7 - 9
      set_reg(4'd4, 16'h0009);
      drive(3'b010, 4'd1, 4'd4, 4'd5, 1'b1);
      chk("sub_alu", ALU_out, 16'hFFFE);
      step();
      idle();
      rd("sub_r5", 4'd5, 16'hFFFE);
      chk("sub_cf", {15'd0, carry_flag}, 16'h0001);
      chk("sub_zf", {15'd0, zero_flag}, 16'h0000);

      // ADD to zero: FFFE + 2 into r0
      set_reg(4'd6, 16'h0002);
      drive(3'b001, 4'd5, 4'd6, 4'd0, 1'b1);
      chk("add_alu", ALU_out, 16'h0000);
      step();
      idle();
      rd("add_r0", 4'd0, 16'h0000);
      chk("add_zf", {15'd0, zero_flag}, 16'h0001);
      chk("add_cf", {15'd0, carry_flag}, 16'h0001);

      // ADD carry with non-zero result: FFFF + 2
      set_reg(4'd8, 16'hFFFF);
      drive(3'b001, 4'd8, 4'd6, 4'd12, 1'b1);
      chk("addc_alu", ALU_out, 16'h0001);
      step();
      idle();
      rd("addc_r12", 4'd12, 16'h0001);
      chk("addc_cf", {15'd0, carry_flag}, 16'h0001);
      chk("addc_zf", {15'd0, zero_flag}, 16'h0000);

      // STORE r0=A5 to 205 over old 1111; same-cycle read returns old
      set_reg(4'd14, 16'h1111);
      store(8'd205, 4'd14);
      set_reg(4'd0, 16'h00A5);
      RF_Ra_addr = 4'd0; D_addr = 8'd205; D_wr = 1'b1; RF_s = 1'b1; RF_W_en = 1'b0;
      step();
      D_wr = 1'b0;
      #1;
      chk("st_old", W_data, 16'h1111);
      step();
      chk("st_new", W_data, 16'h00A5);
      idle();

      // Logic ops with A=00A5, B=0009
      drive(3'b100, 4'd0, 4'd4, 4'd11, 1'b0);
      chk("xor", ALU_out, 16'h00AC);
      drive(3'b101, 4'd0, 4'd4, 4'd11, 1'b0);
      chk("or", ALU_out, 16'h00AD);
      drive(3'b110, 4'd0, 4'd4, 4'd11, 1'b0);
      chk("and", ALU_out, 16'h0001);
      drive(3'b011, 4'd0, 4'd4, 4'd11, 1'b0);
      chk("pass_a", ALU_out, 16'h00A5);
      drive(3'b000, 4'd0, 4'd4, 4'd11, 1'b0);
      chk("zero_op", ALU_out, 16'h0000);

      // Increment wrap: FFFF + 1
      drive(3'b111, 4'd8, 4'd8, 4'd9, 1'b1);
      chk("inc_alu", ALU_out, 16'h0000);
      step();
      idle();
      rd("inc_r9", 4'd9, 16'h0000);
      chk("inc_cf", {15'd0, carry_flag}, 16'h0001);
      chk("inc_zf", {15'd0, zero_flag}, 16'h0001);

      // Logic write clears both flags
      drive(3'b100, 4'd0, 4'd4, 4'd11, 1'b1);
      step();
      idle();
      rd("xor_r11", 4'd11, 16'h00AC);
      chk("xor_cf", {15'd0, carry_flag}, 16'h0000);
      chk("xor_zf", {15'd0, zero_flag}, 16'h0000);

      // Collision: r2 old=3, load 8 into r2 while reading r2 and storing r2 to same address
      set_reg(4'd2, 16'h0003);
      set_reg(4'd14, 16'h0008);
      store(8'd20, 4'd14);
      D_addr = 8'd20;
      step();
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd2; RF_Ra_addr = 4'd2; D_wr = 1'b1;
      #1;
      chk("col_ra_old", Ra_data, 16'h0003);
      chk("col_wdata", W_data, 16'h0008);
      step();
      RF_W_en = 1'b0; D_wr = 1'b0;
      #1;
      chk("col_ra_new", Ra_data, 16'h0008);
      chk("col_dmq_old", W_data, 16'h0008);
      step();
      chk("col_mem20", W_data, 16'h0003);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
Execution datapath that sits directly downstream of the control unit and consumes its per-cycle control word: D_addr, D_wr, RF_s, RF_W_en, RF_Ra_addr, RF_Rb_addr, RF_W_addr and ALU_s0. It contains three pieces: a 16x16 register file, a 3-bit-select ALU, and a 256x16 synchronous data memory. It executes LOAD, STORE, ADD, SUB and the remaining ALU ops, and exposes the A, B and ALU-result buses plus flags for board display.

Parameters:
DW, 16, data width of register file, ALU and data memory words
RF_DEPTH, 16, register file entries (address width 4)
DM_DEPTH, 256, data memory words (address width 8)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears register file, flags and output registers
D_addr  input  8  data memory address
D_wr  input  1  data memory write enable
RF_s  input  1  register file write-data select: 1 = data memory read data, 0 = ALU result
RF_W_en  input  1  register file write enable
RF_W_addr  input  4  register file write address
RF_Ra_addr  input  4  register file read port A address
RF_Rb_addr  input  4  register file read port B address
ALU_s0  input  3  ALU operation select
Ra_data  output  16  register file port A read data
Rb_data  output  16  register file port B read data
ALU_out  output  16  combinational ALU result
W_data  output  16  selected register file write data
zero_flag  output  1  registered: last ALU-sourced write was zero
carry_flag  output  1  registered: carry/borrow of last ALU-sourced write

Behaviour:
- Reset: reset=1 at a posedge clears all 16 registers, zero_flag and carry_flag to 0, and the data memory read register to 0.
  - Ra_data, Rb_data, ALU_out and W_data then follow from the zeroed state.
  - Data memory contents are NOT cleared.
  - reset has priority over RF_W_en and D_wr in the same cycle; D_wr is ignored while reset=1.
- Register file:
  - Two asynchronous read ports.
  - One synchronous write port: RF[RF_W_addr] <= W_data on posedge when RF_W_en=1.
  - Read during a same-cycle write to the same address returns the old value; the new value is visible the next cycle.
  - Register 0 is an ordinary writable register.
- Data memory:
  - Synchronous write: mem[D_addr] <= Ra_data on posedge when D_wr=1.
  - Synchronous read, 1-cycle latency: dm_q <= mem[D_addr] on every posedge.
  - Read-during-write to the same address returns old data.
  - The control unit holds D_addr for at least 2 cycles on LOAD (address cycle, then write-back cycle with RF_s=1, RF_W_en=1).
- W_data = RF_s ? dm_q : ALU_out.
- ALU, unsigned 16-bit, result truncated to 16 bits; c is the internal 17th bit:
  - 000: 0, c=0
  - 001: A+B, c = carry out
  - 010: A-B, c = borrow (A<B)
  - 011: A, c=0
  - 100: A^B, c=0
  - 101: A|B, c=0
  - 110: A&B, c=0
  - 111: A+1, c = carry out
  - A = Ra_data, B = Rb_data.
- Flags update only on posedge with RF_W_en=1 and RF_s=0: zero_flag <= (ALU_out==0), carry_flag <= c. Otherwise they hold.
- Wrap-around: 16'hFFFF+1 = 0 with carry=1; 0-1 = 16'hFFFF with borrow=1.
- Simultaneous D_wr=1 and RF_W_en=1: both commit in the same cycle, independently.
- Reset mid-LOAD: the pending dm_q is discarded (cleared to 0); no register write occurs that cycle.

Test Plan:
- Reset: preload RF[3]=16'h1234, assert reset one cycle -> all RF reads 0, flags 0; mem[5] preloaded 16'hBEEF still reads 16'hBEEF afterwards.
- LOAD: mem[11]=16'h0007; D_addr=11 held 2 cycles, second cycle RF_s=1, RF_W_en=1, RF_W_addr=1 -> RF[1]=16'h0007 next cycle; flags unchanged.
- SUB with borrow: RF[1]=7, RF[4]=9, ALU_s0=010, Ra=1, Rb=4, RF_W_addr=5, RF_W_en=1 -> RF[5]=16'hFFFE, carry_flag=1, zero_flag=0.
- ADD to zero: RF[5]=16'hFFFE, RF[6]=2, ALU_s0=001 into RF[0] -> RF[0]=0, zero_flag=1, carry_flag=1.
- STORE: RF[0]=16'h00A5, Ra=0, D_addr=205, D_wr=1 one cycle -> mem[205] reads 16'h00A5 one cycle after addressing; same-cycle read of 205 returns the old value.
- Write/read collision: RF_W_en=1, RF_W_addr=2=RF_Ra_addr, old=3, new=8 -> Ra_data=3 that cycle, 8 next; ALU_s0=111 on 16'hFFFF -> ALU_out=0, c=1.
